// File: rtl/aes_sbox_arb.sv
// Shares one 32-bit AES sbox between key SubWord requests and 128-bit SubBytes states.
// Latency: key word 1 cycle after grant; state 5 cycles after capture, +1 per key grant taken mid-state.
// Backpressure: requests wait, held stable, until their combinational grant; key wins collisions
//   unless AES_SBOX_ARB_RR_EN is defined, which makes collisions alternate between the two paths.

// Combinational SubWord: four byte sboxes computed as GF(2^8) inverse plus affine map.
module aes_sbox (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse is x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign dout = {sbox_byte(din[31:24]), sbox_byte(din[23:16]),
                 sbox_byte(din[15:8]),  sbox_byte(din[7:0])};

endmodule

module aes_sbox_arb (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_key_req,
  input  logic [31:0]  i_key_wrd,
  output logic         o_key_gnt,
  output logic         o_key_vld,
  output logic [31:0]  o_key_wrd,
  input  logic         i_st_req,
  input  logic [127:0] i_st_blk,
  output logic         o_st_gnt,
  output logic         o_st_vld,
  output logic [127:0] o_st_blk
);

  typedef enum logic {IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [1:0]     wcnt;
  logic [127:0]   cap;
  logic [127:0]   cap_upd;
  logic [31:0]    cap_wrd;
  logic [31:0]    sbox_in;
  logic [31:0]    sbox_out;
  logic           key_win;
  logic           st_win;
  logic           st_cap;
`ifdef AES_SBOX_ARB_RR_EN
  logic           rr_last;  // 1: state won the most recent collision
`endif

  aes_sbox u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Arbitration, capture and next-state decode.
  always_comb begin
    state_nxt = state;
    key_win   = 1'b0;
    st_win    = 1'b0;
    st_cap    = 1'b0;
    case (state)
      IDLE: begin
        key_win = i_key_req;
        // Holding off capture while o_st_vld is high keeps the result slot one-deep.
        st_cap  = i_st_req & ~o_st_vld;
        if (st_cap) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_key_req) begin
`ifdef AES_SBOX_ARB_RR_EN
          key_win = rr_last;
          st_win  = ~rr_last;
`else
          key_win = 1'b1;
`endif
        end else begin
          st_win = 1'b1;
        end
        if (st_win && (wcnt == 2'd3)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are forced low while reset is asserted so every output reads 0 in reset.
  assign o_key_gnt = key_win & i_rst_n;
  assign o_st_gnt  = st_cap & i_rst_n;

  // Pick the current state word and build the capture register with it substituted in place.
  always_comb begin
    cap_wrd = cap[127:96];
    cap_upd = cap;
    case (wcnt)
      2'd0: begin cap_wrd = cap[127:96]; cap_upd[127:96] = sbox_out; end
      2'd1: begin cap_wrd = cap[95:64];  cap_upd[95:64]  = sbox_out; end
      2'd2: begin cap_wrd = cap[63:32];  cap_upd[63:32]  = sbox_out; end
      default: begin cap_wrd = cap[31:0]; cap_upd[31:0] = sbox_out; end
    endcase
  end

  assign sbox_in = key_win ? i_key_wrd : cap_wrd;

  // Datapath: key result, state word sequencing and completed-state result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wcnt      <= 2'd0;
      cap       <= 128'd0;
      o_st_blk  <= 128'd0;
      o_st_vld  <= 1'b0;
      o_key_wrd <= 32'd0;
      o_key_vld <= 1'b0;
    end else begin
      o_key_vld <= key_win;
      if (key_win) o_key_wrd <= sbox_out;
      o_st_vld <= st_win & (wcnt == 2'd3);
      if (st_cap) begin
        cap  <= i_st_blk;
        wcnt <= 2'd0;
      end
      if (st_win) begin
        cap  <= cap_upd;
        wcnt <= wcnt + 2'd1;
        if (wcnt == 2'd3) o_st_blk <= cap_upd;
      end
    end
  end

`ifdef AES_SBOX_ARB_RR_EN
  // Remember the winner of each collision so the other path wins the next one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              rr_last <= 1'b0;
    else if (i_key_req && (state == ST_RUN))   rr_last <= st_win;
  end
`endif

endmodule

// File: tb/tb_aes_sbox_arb.sv
module tb_aes_sbox_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_req;
  logic [31:0]  key_wrd;
  logic         key_gnt;
  logic         key_vld;
  logic [31:0]  key_out;
  logic         st_req;
  logic [127:0] st_blk;
  logic         st_gnt;
  logic         st_vld;
  logic [127:0] st_out;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] BLK_A = 128'h00000000_01010101_53535353_11111111;
  localparam logic [127:0] SUB_A = 128'h63636363_7C7C7C7C_EDEDEDED_82828282;
  localparam logic [127:0] BLK_B = 128'h11111111_53535353_01010101_00000000;
  localparam logic [127:0] SUB_B = 128'h82828282_EDEDEDED_7C7C7C7C_63636363;

  always #5 clk = ~clk;

  aes_sbox_arb dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_key_req (key_req),
    .i_key_wrd (key_wrd),
    .o_key_gnt (key_gnt),
    .o_key_vld (key_vld),
    .o_key_wrd (key_out),
    .i_st_req  (st_req),
    .i_st_blk  (st_blk),
    .o_st_gnt  (st_gnt),
    .o_st_vld  (st_vld),
    .o_st_blk  (st_out)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; key_req = 1'b0; key_wrd = '0; st_req = 1'b0; st_blk = '0;
    step; step;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; key_req = 1'b1; key_wrd = '0; st_req = 1'b1; st_blk = BLK_A;
    #1;
    checks++; if (key_gnt !== 1'b0) begin errors++; $display("FAIL rst_key_gnt got=%0h exp=0", key_gnt); end
    checks++; if (st_gnt !== 1'b0) begin errors++; $display("FAIL rst_st_gnt got=%0h exp=0", st_gnt); end
    key_req = 1'b0; st_req = 1'b0;
    step; step;
    checks++; if (key_vld !== 1'b0 || key_out !== 32'd0) begin errors++; $display("FAIL rst_key_out vld=%0h wrd=%0h exp=0/0", key_vld, key_out); end
    checks++; if (st_vld !== 1'b0 || st_out !== 128'd0) begin errors++; $display("FAIL rst_st_out vld=%0h blk=%0h exp=0/0", st_vld, st_out); end
    rst_n = 1'b1;
    step; step; step;
    checks++; if ({key_gnt, key_vld, st_gnt, st_vld} !== 4'b0) begin errors++; $display("FAIL idle_ctl got=%b exp=0000", {key_gnt, key_vld, st_gnt, st_vld}); end
    checks++; if (key_out !== 32'd0 || st_out !== 128'd0) begin errors++; $display("FAIL idle_dat key=%0h st=%0h exp=0", key_out, st_out); end
  endtask

  task automatic test_key_single;
    do_reset;
    key_req = 1'b1; key_wrd = 32'h00000000; #1;
    checks++; if (key_gnt !== 1'b1) begin errors++; $display("FAIL key0_gnt got=%0h exp=1", key_gnt); end
    checks++; if (key_vld !== 1'b0) begin errors++; $display("FAIL key0_vld_early got=%0h exp=0", key_vld); end
    step; key_req = 1'b0;
    checks++; if (key_vld !== 1'b1 || key_out !== 32'h63636363) begin errors++; $display("FAIL key0_res vld=%0h wrd=%0h exp=1/63636363", key_vld, key_out); end
    key_req = 1'b1; key_wrd = 32'h01010101; #1;
    checks++; if (key_gnt !== 1'b1) begin errors++; $display("FAIL key1_gnt got=%0h exp=1", key_gnt); end
    step; key_req = 1'b0;
    checks++; if (key_vld !== 1'b1 || key_out !== 32'h7C7C7C7C) begin errors++; $display("FAIL key1_res vld=%0h wrd=%0h exp=1/7c7c7c7c", key_vld, key_out); end
    step;
    checks++; if (key_vld !== 1'b0 || key_out !== 32'h7C7C7C7C) begin errors++; $display("FAIL key1_hold vld=%0h wrd=%0h exp=0/7c7c7c7c", key_vld, key_out); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    key_req = 1'b1; key_wrd = 32'h53535353;
    step; key_wrd = 32'h11111111; #1;
    checks++; if (key_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt got=%0h exp=1", key_gnt); end
    checks++; if (key_vld !== 1'b1 || key_out !== 32'hEDEDEDED) begin errors++; $display("FAIL b2b_res0 vld=%0h wrd=%0h exp=1/ededeDED", key_vld, key_out); end
    step; key_req = 1'b0;
    checks++; if (key_vld !== 1'b1 || key_out !== 32'h82828282) begin errors++; $display("FAIL b2b_res1 vld=%0h wrd=%0h exp=1/82828282", key_vld, key_out); end
    step;
    checks++; if (key_vld !== 1'b0) begin errors++; $display("FAIL b2b_vld_end got=%0h exp=0", key_vld); end
  endtask

  task automatic test_state_single;
    do_reset;
    st_req = 1'b1; st_blk = BLK_A; #1;
    checks++; if (st_gnt !== 1'b1) begin errors++; $display("FAIL st_gnt got=%0h exp=1", st_gnt); end
    step; st_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++; if (st_vld !== (c == 5)) begin errors++; $display("FAIL st_vld_c%0d got=%0h exp=%0h", c, st_vld, (c == 5)); end
      if (c < 5) begin
        checks++; if (st_out !== 128'd0) begin errors++; $display("FAIL st_hold_c%0d got=%0h exp=0", c, st_out); end
        step;
      end
    end
    checks++; if (st_out !== SUB_A) begin errors++; $display("FAIL st_res got=%0h exp=%0h", st_out, SUB_A); end
    st_req = 1'b1; st_blk = BLK_B; #1;
    checks++; if (st_gnt !== 1'b0) begin errors++; $display("FAIL st_gnt_during_vld got=%0h exp=0", st_gnt); end
    step;
    checks++; if (st_gnt !== 1'b1) begin errors++; $display("FAIL st_gnt_after_vld got=%0h exp=1", st_gnt); end
    st_req = 1'b0;
  endtask

  task automatic test_collision;
    int cyc;
    int vld_at;
    logic [127:0] res;
    do_reset;
    st_req = 1'b1; st_blk = BLK_A;
    step; st_req = 1'b0;
    step; key_req = 1'b1; key_wrd = 32'h53535353; #1;
    cyc = 2;
`ifdef AES_SBOX_ARB_RR_EN
    checks++; if (key_gnt !== 1'b0) begin errors++; $display("FAIL col_gnt_n2 got=%0h exp=0", key_gnt); end
    step; cyc++;
    checks++; if (key_gnt !== 1'b1) begin errors++; $display("FAIL col_gnt_n3 got=%0h exp=1", key_gnt); end
`else
    checks++; if (key_gnt !== 1'b1) begin errors++; $display("FAIL col_gnt_n2 got=%0h exp=1", key_gnt); end
`endif
    step; cyc++; key_req = 1'b0;
    checks++; if (key_vld !== 1'b1 || key_out !== 32'hEDEDEDED) begin errors++; $display("FAIL col_key_res vld=%0h wrd=%0h exp=1/ededeDED", key_vld, key_out); end
    vld_at = -1; res = '0;
    while (cyc < 12) begin
      if (st_vld === 1'b1 && vld_at < 0) begin vld_at = cyc; res = st_out; end
      step; cyc++;
    end
    checks++; if (vld_at != 6) begin errors++; $display("FAIL col_st_vld_cycle got=%0d exp=6", vld_at); end
    checks++; if (res !== SUB_A) begin errors++; $display("FAIL col_st_res got=%0h exp=%0h", res, SUB_A); end
  endtask

  task automatic test_starvation;
    int vld_at;
    logic exp_gnt;
    logic [127:0] res;
    do_reset;
    key_req = 1'b1; key_wrd = 32'h0; st_req = 1'b1; st_blk = BLK_A;
    vld_at = -1; res = '0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) st_req = 1'b0;
      #1;
      if (c == 0) begin
        checks++; if (st_gnt !== 1'b1) begin errors++; $display("FAIL stv_st_gnt got=%0h exp=1", st_gnt); end
      end
`ifdef AES_SBOX_ARB_RR_EN
      exp_gnt = (c >= 8) || (c % 2 == 0);
`else
      exp_gnt = 1'b1;
`endif
      checks++; if (key_gnt !== exp_gnt) begin errors++; $display("FAIL stv_key_gnt_c%0d got=%0h exp=%0h", c, key_gnt, exp_gnt); end
      if (st_vld === 1'b1 && vld_at < 0) begin vld_at = c; res = st_out; end
      @(posedge clk); #1;
    end
    key_req = 1'b0;
`ifdef AES_SBOX_ARB_RR_EN
    checks++; if (vld_at != 8) begin errors++; $display("FAIL stv_vld_cycle got=%0d exp=8", vld_at); end
    checks++; if (res !== SUB_A) begin errors++; $display("FAIL stv_res got=%0h exp=%0h", res, SUB_A); end
`else
    checks++; if (vld_at != -1) begin errors++; $display("FAIL stv_vld_cycle got=%0d exp=none", vld_at); end
`endif
  endtask

  task automatic test_reset_mid;
    logic seen;
    int vld_at;
    do_reset;
    key_req = 1'b1; key_wrd = 32'h0;
    step; key_req = 1'b0;
    st_req = 1'b1; st_blk = BLK_A;
    step; st_req = 1'b0;
    step; step;
    rst_n = 1'b0; #1;
    checks++; if (key_out !== 32'd0 || key_vld !== 1'b0) begin errors++; $display("FAIL rmid_key wrd=%0h vld=%0h exp=0/0", key_out, key_vld); end
    checks++; if (st_vld !== 1'b0 || st_out !== 128'd0) begin errors++; $display("FAIL rmid_st vld=%0h blk=%0h exp=0/0", st_vld, st_out); end
    step; rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (st_vld === 1'b1) seen = 1'b1;
      step;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_stray_vld got=%0h exp=0", seen); end
    st_req = 1'b1; st_blk = BLK_B; #1;
    checks++; if (st_gnt !== 1'b1) begin errors++; $display("FAIL rmid_new_gnt got=%0h exp=1", st_gnt); end
    step; st_req = 1'b0;
    vld_at = -1;
    for (int c = 1; c < 10; c++) begin
      if (st_vld === 1'b1 && vld_at < 0) begin
        vld_at = c;
        checks++; if (st_out !== SUB_B) begin errors++; $display("FAIL rmid_new_res got=%0h exp=%0h", st_out, SUB_B); end
      end
      step;
    end
    checks++; if (vld_at != 5) begin errors++; $display("FAIL rmid_new_vld_cycle got=%0d exp=5", vld_at); end
  endtask

  initial begin
    test_reset;
    test_key_single;
    test_back_to_back;
    test_state_single;
    test_collision;
    test_starvation;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
